// File: rtl/dmem_pkg.sv
// Shared types for the data-memory line responder: request opcodes,
// responder states and the default line geometry.
package dmem_pkg;

  localparam int DEFAULT_WORDS_PER_LINE = 8;

  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_FILL    = 2'b01,
    OP_WB      = 2'b10,
    OP_WB_FILL = 2'b11
  } line_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WB   = 2'b01,
    S_FILL = 2'b10,
    S_DONE = 2'b11
  } resp_state_t;

endpackage

// File: rtl/dmem_line_responder_if.sv
// Request, writeback, fill and BRAM signals between the cache controller,
// the line responder and the data BRAM.
interface dmem_line_responder_if
  import dmem_pkg::*;
#(
  parameter int WORDS_PER_LINE = DEFAULT_WORDS_PER_LINE,
  parameter int ADDR_WIDTH     = 14,
  parameter int DATA_WIDTH     = 32
);
  localparam int IDX_W  = $clog2(WORDS_PER_LINE);
  localparam int LINE_W = ADDR_WIDTH - IDX_W;

  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_op;
  logic [LINE_W-1:0]     req_fill_line;
  logic [LINE_W-1:0]     req_wb_line;
  logic [IDX_W-1:0]      wb_idx;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  fill_valid;
  logic [IDX_W-1:0]      fill_idx;
  logic [DATA_WIDTH-1:0] fill_data;
  logic                  fill_last;
  logic                  done;
  logic                  busy;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic                  mem_re;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Cache controller plus BRAM side.
  modport master (
    output req_valid, req_op, req_fill_line, req_wb_line, wb_data, mem_rdata,
    input  req_ready, wb_idx, fill_valid, fill_idx, fill_data, fill_last,
           done, busy, mem_addr, mem_we, mem_re, mem_wdata
  );

  // Responder side.
  modport slave (
    input  req_valid, req_op, req_fill_line, req_wb_line, wb_data, mem_rdata,
    output req_ready, wb_idx, fill_valid, fill_idx, fill_data, fill_last,
           done, busy, mem_addr, mem_we, mem_re, mem_wdata
  );

endinterface

// File: rtl/beat_counter.sv
// Beat counter with synchronous clear and enable; flags when the count
// equals TERM.
module beat_counter #(
  parameter int W    = 4,
  parameter int TERM = 7
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         at_term
);

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge CLK) begin
    if (RST || clr) count <= '0;
    else if (en)    count <= count + W'(1);
  end

  assign at_term = (count == W'(TERM));

endmodule

// File: rtl/dmem_line_responder.sv
// Line-transfer responder: sequences word-wise BRAM writes for writebacks
// and pipelined BRAM reads for fills, one request at a time.
module dmem_line_responder
  import dmem_pkg::*;
#(
  parameter int WORDS_PER_LINE = DEFAULT_WORDS_PER_LINE,
  parameter int ADDR_WIDTH     = 14,
  parameter int DATA_WIDTH     = 32
) (
  input logic                  CLK,
  input logic                  RST,
  dmem_line_responder_if.slave bus
);

  localparam int IDX_W  = $clog2(WORDS_PER_LINE);
  localparam int LINE_W = ADDR_WIDTH - IDX_W;
  localparam int CNT_W  = IDX_W + 1;

  resp_state_t       state, state_d;
  line_op_t          op_q;
  logic [LINE_W-1:0] fill_line_q, wb_line_q;

  logic [CNT_W-1:0]  cnt;
  logic              cnt_clr, cnt_en, wb_last;
  logic              accept;

  logic                  req_ready_c, busy_c, done_c;
  logic                  mem_we_c, mem_re_c;
  logic [ADDR_WIDTH-1:0] mem_addr_c;
  logic [DATA_WIDTH-1:0] mem_wdata_c, fill_data_c;
  logic [IDX_W-1:0]      wb_idx_c, fill_idx_c;
  logic                  fill_valid_c, fill_last_c;

  // Shared by both phases; the terminal flag marks the last writeback word,
  // while the fill phase runs one past the line to drain the read pipeline.
  beat_counter #(.W(CNT_W), .TERM(WORDS_PER_LINE - 1)) u_cnt (
    .CLK     (CLK),
    .RST     (RST),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .count   (cnt),
    .at_term (wb_last)
  );

  assign accept = bus.req_valid && req_ready_c;

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_d;
  end

  // NOTE: the request latches are reset too, so a post-reset address bus
  // never carries stale line numbers into simulation or silicon.
  always_ff @(posedge CLK) begin
    if (RST) begin
      op_q        <= OP_NOP;
      fill_line_q <= '0;
      wb_line_q   <= '0;
    end else if (accept) begin
      op_q        <= line_op_t'(bus.req_op);
      fill_line_q <= bus.req_fill_line;
      wb_line_q   <= bus.req_wb_line;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // infer a latch; reset then forces all outputs quiet combinationally.
  always_comb begin
    state_d      = state;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
    req_ready_c  = 1'b0;
    busy_c       = 1'b0;
    done_c       = 1'b0;
    mem_we_c     = 1'b0;
    mem_re_c     = 1'b0;
    mem_addr_c   = '0;
    mem_wdata_c  = '0;
    wb_idx_c     = '0;
    fill_valid_c = 1'b0;
    fill_idx_c   = '0;
    fill_data_c  = '0;
    fill_last_c  = 1'b0;

    if (RST) begin
      state_d = S_IDLE;
    end else begin
      busy_c = (state != S_IDLE);
      unique case (state)
        S_IDLE: begin
          req_ready_c = 1'b1;
          cnt_clr     = 1'b1;
          if (bus.req_valid) begin
            unique case (line_op_t'(bus.req_op))
              OP_NOP:  state_d = S_DONE;
              OP_FILL: state_d = S_FILL;
              default: state_d = S_WB;
            endcase
          end
        end
        S_WB: begin
          wb_idx_c    = cnt[IDX_W-1:0];
          mem_we_c    = 1'b1;
          mem_addr_c  = {wb_line_q, cnt[IDX_W-1:0]};
          mem_wdata_c = bus.wb_data;
          if (wb_last) begin
            cnt_clr = 1'b1;
            state_d = (op_q == OP_WB_FILL) ? S_FILL : S_DONE;
          end else begin
            cnt_en = 1'b1;
          end
        end
        S_FILL: begin
          if (!cnt[IDX_W]) begin
            mem_re_c   = 1'b1;
            mem_addr_c = {fill_line_q, cnt[IDX_W-1:0]};
          end
          // Read data lags the issue by one cycle, so beat i-1 lands now.
          if (cnt != '0) begin
            fill_valid_c = 1'b1;
            fill_idx_c   = cnt[IDX_W-1:0] - IDX_W'(1);
            fill_data_c  = bus.mem_rdata;
          end
          if (cnt[IDX_W]) begin
            fill_last_c = 1'b1;
            state_d     = S_DONE;
          end else begin
            cnt_en = 1'b1;
          end
        end
        S_DONE: begin
          done_c  = 1'b1;
          cnt_clr = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.mem_we     = mem_we_c;
  assign bus.mem_re     = mem_re_c;
  assign bus.mem_addr   = mem_addr_c;
  assign bus.mem_wdata  = mem_wdata_c;
  assign bus.wb_idx     = wb_idx_c;
  assign bus.fill_valid = fill_valid_c;
  assign bus.fill_idx   = fill_idx_c;
  assign bus.fill_data  = fill_data_c;
  assign bus.fill_last  = fill_last_c;

endmodule

// File: tb/tb_dmem_line_responder.sv
// Self-checking bench: acts as cache and BRAM, predicts every output per
// cycle from the transfer timing rules and compares on the falling edge.
module tb_dmem_line_responder;
  import dmem_pkg::*;

  localparam int W      = 8;
  localparam int AW     = 14;
  localparam int DW     = 32;
  localparam int IDX_W  = 3;
  localparam int LINE_W = AW - IDX_W;

  typedef struct {
    logic          req_ready, busy, done, mem_we, mem_re, fill_valid, fill_last;
    logic [AW-1:0] mem_addr;
    logic [IDX_W-1:0] wb_idx, fill_idx;
    logic [DW-1:0] mem_wdata, fill_data;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  dmem_line_responder_if #(.WORDS_PER_LINE(W), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  dmem_line_responder #(.WORDS_PER_LINE(W), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  logic [DW-1:0] bram    [2**AW];
  logic [DW-1:0] ref_mem [2**AW];
  logic [DW-1:0] cache_line [W];
  logic [DW-1:0] rdata_q;

  // Synchronous single-port BRAM driven by the responder.
  always @(posedge CLK) begin
    if (bus.mem_we) bram[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) rdata_q <= bram[bus.mem_addr];
  end
  assign bus.mem_rdata = rdata_q;
  assign bus.wb_data   = cache_line[bus.wb_idx];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cur_t = -1;
  int   done_t = -1;
  logic [DW-1:0] last_beat = '0;
  bit   chk_en = 1'b0;
  exp_t expv;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at t=%0d: got %0h, expected %0h", name, cur_t, act, req);
    end
  endtask

  function automatic exp_t quiet(input bit ready);
    exp_t e;
    e = '{default: '0};
    e.req_ready = ready;
    return e;
  endfunction

  function automatic int latency(input logic [1:0] op);
    return (op[1] ? W : 0) + (op[0] ? W + 1 : 0) + 1;
  endfunction

  // Expected outputs t cycles after acceptance, from the phase timing rules.
  function automatic exp_t model_at(input logic [1:0] op, input int fl, input int wl, input int t);
    exp_t e;
    int nwb, f0, len;
    e   = quiet(1'b0);
    nwb = op[1] ? W : 0;
    f0  = nwb + 1;
    len = latency(op);
    if (t == 0 || t > len) e.req_ready = 1'b1;
    else                   e.busy = 1'b1;
    if (t >= 1 && t <= nwb) begin
      e.mem_we    = 1'b1;
      e.wb_idx    = IDX_W'(t - 1);
      e.mem_addr  = AW'(wl * W + t - 1);
      e.mem_wdata = cache_line[t-1];
    end
    if (op[0] && t >= f0 && t < f0 + W) begin
      e.mem_re   = 1'b1;
      e.mem_addr = AW'(fl * W + t - f0);
    end
    if (op[0] && t > f0 && t <= f0 + W) begin
      e.fill_valid = 1'b1;
      e.fill_idx   = IDX_W'(t - f0 - 1);
      e.fill_data  = ref_mem[fl * W + t - f0 - 1];
      e.fill_last  = (t - f0 - 1 == W - 1);
    end
    if (t == len) e.done = 1'b1;
    return e;
  endfunction

  always @(negedge CLK) begin
    if (chk_en) begin
      check("req_ready",  64'(bus.req_ready),  64'(expv.req_ready));
      check("busy",       64'(bus.busy),       64'(expv.busy));
      check("done",       64'(bus.done),       64'(expv.done));
      check("mem_we",     64'(bus.mem_we),     64'(expv.mem_we));
      check("mem_re",     64'(bus.mem_re),     64'(expv.mem_re));
      check("mem_addr",   64'(bus.mem_addr),   64'(expv.mem_addr));
      check("mem_wdata",  64'(bus.mem_wdata),  64'(expv.mem_wdata));
      check("wb_idx",     64'(bus.wb_idx),     64'(expv.wb_idx));
      check("fill_valid", 64'(bus.fill_valid), 64'(expv.fill_valid));
      check("fill_idx",   64'(bus.fill_idx),   64'(expv.fill_idx));
      check("fill_data",  64'(bus.fill_data),  64'(expv.fill_data));
      check("fill_last",  64'(bus.fill_last),  64'(expv.fill_last));
      check("we_re_excl", 64'(bus.mem_we & bus.mem_re), 64'(0));
      if (bus.done) done_t = cur_t;
      if (bus.fill_valid && bus.fill_last) last_beat = bus.fill_data;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_garbage();
    bus.req_valid     = 1'b1;
    bus.req_op        = 2'($urandom_range(0, 3));
    bus.req_fill_line = LINE_W'($urandom);
    bus.req_wb_line   = LINE_W'($urandom);
  endtask

  task automatic idle_slot();
    bus.req_valid = 1'b0;
    cur_t = -1;
    expv  = quiet(1'b1);
    step();
  endtask

  // Issues one request in the current (idle) cycle and walks it to completion.
  // hold keeps req_valid high with junk while busy; garbage_t pulses junk once;
  // abort_t raises RST at that cycle instead of finishing.
  task automatic run_req(input logic [1:0] op, input int fl, input int wl,
                         input bit hold, input int garbage_t, input int abort_t);
    int len;
    len = latency(op);
    if (op[1]) for (int j = 0; j < W; j++) ref_mem[wl * W + j] = cache_line[j];
    done_t            = -1;
    bus.req_valid     = 1'b1;
    bus.req_op        = op;
    bus.req_fill_line = LINE_W'(fl);
    bus.req_wb_line   = LINE_W'(wl);
    cur_t = 0;
    expv  = model_at(op, fl, wl, 0);
    for (int t = 1; t <= len; t++) begin
      step();
      cur_t = t;
      if (t == abort_t) begin
        RST  = 1'b1;
        drive_garbage();
        expv = quiet(1'b0);
        step();
        RST = 1'b0;
        bus.req_valid = 1'b0;
        return;
      end
      if (hold || t == garbage_t) drive_garbage();
      else bus.req_valid = 1'b0;
      expv = model_at(op, fl, wl, t);
    end
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic set_cache(input logic [DW-1:0] base, input bit rnd);
    for (int j = 0; j < W; j++) cache_line[j] = rnd ? DW'($urandom) : base + DW'(j);
  endtask

  initial begin
    bus.req_valid     = 1'b0;
    bus.req_op        = 2'b00;
    bus.req_fill_line = '0;
    bus.req_wb_line   = '0;
    rdata_q           = '0;
    for (int i = 0; i < 2**AW; i++) begin
      bram[i]    = DW'($urandom);
      ref_mem[i] = bram[i];
    end
    for (int j = 0; j < W; j++) begin
      bram[14'h0090 + j]    = 32'hA0 + DW'(j);
      ref_mem[14'h0090 + j] = 32'hA0 + DW'(j);
    end
    set_cache(32'h0, 1'b0);

    // Reset: valid asserted alongside RST must not be accepted.
    @(posedge CLK);
    @(posedge CLK);
    #1;
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b01;
    chk_en = 1'b1;
    cur_t  = -1;
    expv   = quiet(1'b0);
    step();
    step();
    RST = 1'b0;
    bus.req_valid = 1'b0;
    expv = quiet(1'b1);
    step();

    // Fill of line 0x012.
    run_req(OP_FILL, 'h012, 0, 1'b0, 0, 0);
    check("fill_done_cycle", 64'(done_t), 64'(10));
    check("fill_last_data",  64'(last_beat), 64'h0A7);

    // Writeback of line 0x034 with a junk request pulsed mid-transfer.
    set_cache(32'hB0, 1'b0);
    run_req(OP_WB, 0, 'h034, 1'b0, 4, 0);
    check("wb_done_cycle", 64'(done_t), 64'(9));
    check("wb_word0", 64'(bram[14'h01A0]), 64'h0B0);
    check("wb_word7", 64'(bram[14'h01A7]), 64'h0B7);

    // Writeback-then-fill.
    set_cache(32'hC0, 1'b0);
    run_req(OP_WB_FILL, 'h012, 'h034, 1'b0, 0, 0);
    check("wbf_done_cycle", 64'(done_t), 64'(18));
    check("wbf_word3", 64'(bram[14'h01A3]), 64'h0C3);
    check("wbf_last_data", 64'(last_beat), 64'h0A7);

    // Nop then back-to-back fills with req_valid held high.
    run_req(OP_NOP, 0, 0, 1'b1, 0, 0);
    check("nop_done_cycle", 64'(done_t), 64'(1));
    run_req(OP_FILL, 'h012, 0, 1'b1, 0, 0);
    check("b2b_done_cycle", 64'(done_t), 64'(10));
    run_req(OP_FILL, 'h005, 0, 1'b1, 0, 0);

    // Reset during a fill, then a clean fill.
    run_req(OP_FILL, 'h012, 0, 1'b0, 0, 4);
    check("abort_no_done", 64'(done_t), 64'(-1));
    run_req(OP_FILL, 'h012, 0, 1'b0, 0, 0);
    check("post_abort_last", 64'(last_beat), 64'h0A7);

    // Randomized traffic over a small set of lines so writes and fills collide.
    for (int n = 0; n < 60; n++) begin
      set_cache(32'h0, 1'b1);
      run_req(2'($urandom_range(0, 3)), $urandom_range(0, 15), $urandom_range(0, 15),
              1'($urandom_range(0, 1)), $urandom_range(0, 6), 0);
      if ($urandom_range(0, 2) == 0) idle_slot();
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
